axi_lite_rr_master_arbiter: RTL and testbench
=============================================

Name: axi_lite_rr_master_arbiter

Overview:
- Shares one AXI4-Lite master port between N_REQ simple register-access requesters.
- Each requester posts single read/write commands; the block arbitrates round-robin, sequences the AXI-Lite handshakes one transaction at a time, and returns data/response with a done pulse.
- Sits between local control engines (CPU shim, init sequencer, debug port) and the 4-register AXI-Lite slave blocks of the design.

Parameters:
- AXI_DATA_WIDTH, 32, data bus width; must be 32 or 64.
- AXI_ADDR_WIDTH, 4, address width.
- N_REQ, 2, number of requesters; must be 2..8.

Ports:
- M_AXI_ACLK  in  1  clock; all logic on rising edge.
- M_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- req_valid  in  N_REQ  per-requester command pending; must be held with fields stable until matching req_done.
- req_write  in  N_REQ  1 = write, 0 = read.
- req_addr  in  N_REQ*AXI_ADDR_WIDTH  packed byte addresses; requester i uses slice i.
- req_wdata  in  N_REQ*AXI_DATA_WIDTH  packed write data.
- req_wstrb  in  N_REQ*AXI_DATA_WIDTH/8  packed byte strobes.
- req_done  out  N_REQ  one-hot, one-cycle pulse: transaction of requester i complete.
- rsp_rdata  out  AXI_DATA_WIDTH  read data; valid in the req_done cycle, held until next done.
- rsp_resp  out  2  BRESP/RRESP of completed transaction; same timing as rsp_rdata.
- busy  out  1  high from grant until the req_done cycle inclusive.
- M_AXI_AWADDR/AWPROT/AWVALID  out  AW/3/1  write address channel; AWPROT fixed 3'b000.
- M_AXI_AWREADY  in  1.
- M_AXI_WDATA/WSTRB/WVALID  out  DW/DW/8/1  write data channel.
- M_AXI_WREADY  in  1.
- M_AXI_BRESP/BVALID  in  2/1; M_AXI_BREADY  out  1.
- M_AXI_ARADDR/ARPROT/ARVALID  out  AW/3/1; ARPROT fixed 3'b000.
- M_AXI_ARREADY  in  1.
- M_AXI_RDATA/RRESP/RVALID  in  DW/2/1; M_AXI_RREADY  out  1.

Behaviour:
- Reset: all AXI VALID/READY outputs 0, addr/data/strb 0, req_done 0, rsp_rdata 0, rsp_resp 0, busy 0, FSM IDLE, last-grant pointer N_REQ-1 so requester 0 wins first.
- FSM states: IDLE, WR (AW+W), WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE: if any req_valid, the rr_arbiter picks the first asserted index after the last grant, wrapping modulo N_REQ.
  - On that edge: register the index, addr, wdata and wstrb; update the pointer; busy goes 1.
  - Next state is WR if req_write, else RD_ADDR. No AXI output is driven combinationally from req_*.
- WR: AWVALID and WVALID rise together on state entry.
  - Each drops on the cycle after its own READY handshake; AW and W may complete in either order or the same cycle.
  - Go to WR_RESP once both are done. AWADDR/WDATA stay stable while the respective VALID is high.
- WR_RESP: BREADY=1. On BVALID, capture BRESP into rsp_resp, leave rsp_rdata unchanged, go to DONE.
- RD_ADDR: ARVALID=1 until ARREADY, then RD_DATA.
- RD_DATA: RREADY=1. On RVALID, capture RDATA/RRESP, go to DONE.
- DONE: req_done[grant]=1 for exactly one cycle, then IDLE. busy drops to 0 in the IDLE cycle after DONE.
- Minimum latency, slave with READY in the first VALID cycle and B/R one cycle later:
  - Write: grant edge to done pulse = 4 cycles.
  - Read: grant edge to done pulse = 4 cycles.
  - Back-to-back transactions are separated by one IDLE cycle.
- Non-OKAY BRESP/RRESP is passed through unchanged; there is no retry.
- If req_valid drops mid-transaction, the transaction still completes and the done pulse is still issued.
- A requester re-asserting in the IDLE cycle after its own done loses to any other pending requester (fairness).
- Simultaneous requests all get served, each within N_REQ transactions.
- No timeout: a slave that never handshakes stalls the block indefinitely.
- Reset mid-transaction: outputs return to reset values asynchronously; the pending transaction is dropped with no done pulse.

Decomposition:
- Package axi_lite_pkg holds:
  - axi_resp_t enum: OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11.
  - arb_state_t enum for the FSM states.
  - Localparam PROT_DEFAULT=3'b000.
- Sub-module rr_arbiter:
  - Parameter N_REQ; inputs req vector and pointer; outputs one-hot grant and grant index.
  - Combinational find-first-after-pointer; the pointer register lives in the top.

Test Plan:
- Reset, then req0 writes addr 0x4, data 0xDEADBEEF, strb 0xF, against the 4-register AXI-Lite slave -> AWVALID and WVALID high together; req_done=2'b01 once; rsp_resp=OKAY; a later read of 0x4 returns rsp_rdata=0xDEADBEEF.
- req0 and req1 assert in the same cycle (req0 write 0x8 = 0x11111111, req1 read 0x8) -> req0 is served first, then req1; req1 sees rsp_rdata=0x11111111; done pulses come in order 01 then 10.
- Both requesters held continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; no requester is granted twice in a row.
- Write with strb 4'b0011 data 0xAAAABBBB over reg=0x12345678 -> readback 0x1234BBBB.
- Slave model delays AWREADY by 3 cycles, asserts WREADY immediately, then returns BRESP=SLVERR -> WVALID drops after 1 cycle while AWVALID is held 4 cycles; rsp_resp=2'b10.
- Assert M_AXI_ARESETN=0 while in RD_DATA -> ARVALID/RREADY/busy go 0 immediately with no req_done; after release, req0 is granted first.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared AXI4-Lite response codes, arbiter FSM states and fixed channel constants
// used by the round-robin master arbiter and its requester-select logic.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } axi_resp_t;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    DONE
  } arb_state_t;

  localparam logic [2:0] PROT_DEFAULT = 3'b000;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: first asserted request strictly after the
// last-granted index, wrapping modulo N_REQ. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int IDX_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_grant,
  output logic [IDX_W-1:0] o_idx
);

  logic             w_found;
  logic [IDX_W-1:0] w_cand;

  // Scanning from ptr+1 makes the last winner the lowest priority next round.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      w_cand = IDX_W'((int'(i_ptr) + k) % N_REQ);
      if (!w_found && i_req[w_cand]) begin
        w_found         = 1'b1;
        o_idx           = w_cand;
        o_grant[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_lite_rr_master_arbiter.sv
// Shares one AXI4-Lite master port between N_REQ register-access requesters,
// running one single-beat transaction at a time in round-robin order.
module axi_lite_rr_master_arbiter
  import axi_lite_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 4,
  parameter int N_REQ          = 2
) (
  input  logic                                M_AXI_ACLK,
  input  logic                                M_AXI_ARESETN,
  input  logic [N_REQ-1:0]                    req_valid,
  input  logic [N_REQ-1:0]                    req_write,
  input  logic [N_REQ*AXI_ADDR_WIDTH-1:0]     req_addr,
  input  logic [N_REQ*AXI_DATA_WIDTH-1:0]     req_wdata,
  input  logic [N_REQ*AXI_DATA_WIDTH/8-1:0]   req_wstrb,
  output logic [N_REQ-1:0]                    req_done,
  output logic [AXI_DATA_WIDTH-1:0]           rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                busy,
  output logic [AXI_ADDR_WIDTH-1:0]           M_AXI_AWADDR,
  output logic [2:0]                          M_AXI_AWPROT,
  output logic                                M_AXI_AWVALID,
  input  logic                                M_AXI_AWREADY,
  output logic [AXI_DATA_WIDTH-1:0]           M_AXI_WDATA,
  output logic [AXI_DATA_WIDTH/8-1:0]         M_AXI_WSTRB,
  output logic                                M_AXI_WVALID,
  input  logic                                M_AXI_WREADY,
  input  logic [1:0]                          M_AXI_BRESP,
  input  logic                                M_AXI_BVALID,
  output logic                                M_AXI_BREADY,
  output logic [AXI_ADDR_WIDTH-1:0]           M_AXI_ARADDR,
  output logic [2:0]                          M_AXI_ARPROT,
  output logic                                M_AXI_ARVALID,
  input  logic                                M_AXI_ARREADY,
  input  logic [AXI_DATA_WIDTH-1:0]           M_AXI_RDATA,
  input  logic [1:0]                          M_AXI_RRESP,
  input  logic                                M_AXI_RVALID,
  output logic                                M_AXI_RREADY
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int STRB_W = AXI_DATA_WIDTH / 8;

  arb_state_t                r_state;
  arb_state_t                w_state_nxt;
  logic                      r_awvalid;
  logic                      r_wvalid;
  logic                      w_awvalid_nxt;
  logic                      w_wvalid_nxt;
  logic                      w_grant_take;
  logic                      w_cap_b;
  logic                      w_cap_r;
  logic [IDX_W-1:0]          r_ptr;
  logic [N_REQ-1:0]          r_grant;
  logic [AXI_ADDR_WIDTH-1:0] r_addr;
  logic [AXI_DATA_WIDTH-1:0] r_wdata;
  logic [STRB_W-1:0]         r_wstrb;
  logic [AXI_DATA_WIDTH-1:0] r_rdata;
  logic [1:0]                r_resp;
  logic [N_REQ-1:0]          w_gnt_onehot;
  logic [IDX_W-1:0]          w_gnt_idx;
  logic                      w_any_req;

  assign w_any_req = |req_valid;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_gnt_onehot),
    .o_idx   (w_gnt_idx)
  );

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_state   <= IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_awvalid <= w_awvalid_nxt;
      r_wvalid  <= w_wvalid_nxt;
    end
  end

  // AW and W retire independently; a channel counts as done once its VALID is low.
  always_comb begin
    w_state_nxt   = r_state;
    w_awvalid_nxt = r_awvalid;
    w_wvalid_nxt  = r_wvalid;
    w_grant_take  = 1'b0;
    w_cap_b       = 1'b0;
    w_cap_r       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_req) begin
          w_grant_take = 1'b1;
          if (req_write[w_gnt_idx]) begin
            w_state_nxt   = WR;
            w_awvalid_nxt = 1'b1;
            w_wvalid_nxt  = 1'b1;
          end else begin
            w_state_nxt = RD_ADDR;
          end
        end
      end
      WR: begin
        if (r_awvalid && M_AXI_AWREADY) w_awvalid_nxt = 1'b0;
        if (r_wvalid && M_AXI_WREADY)   w_wvalid_nxt  = 1'b0;
        if (!w_awvalid_nxt && !w_wvalid_nxt) w_state_nxt = WR_RESP;
      end
      WR_RESP: begin
        if (M_AXI_BVALID) begin
          w_cap_b     = 1'b1;
          w_state_nxt = DONE;
        end
      end
      RD_ADDR: begin
        if (M_AXI_ARREADY) w_state_nxt = RD_DATA;
      end
      RD_DATA: begin
        if (M_AXI_RVALID) begin
          w_cap_r     = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Request fields are latched at grant so the AXI side never follows req_* live.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_ptr   <= IDX_W'(N_REQ - 1);
      r_grant <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_resp  <= OKAY;
    end else begin
      if (w_grant_take) begin
        r_ptr   <= w_gnt_idx;
        r_grant <= w_gnt_onehot;
        r_addr  <= req_addr[int'(w_gnt_idx)*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
        r_wdata <= req_wdata[int'(w_gnt_idx)*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
        r_wstrb <= req_wstrb[int'(w_gnt_idx)*STRB_W +: STRB_W];
      end
      if (w_cap_b) r_resp <= M_AXI_BRESP;
      if (w_cap_r) begin
        r_rdata <= M_AXI_RDATA;
        r_resp  <= M_AXI_RRESP;
      end
    end
  end

  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWPROT  = PROT_DEFAULT;
  assign M_AXI_AWVALID = r_awvalid;
  assign M_AXI_WDATA   = r_wdata;
  assign M_AXI_WSTRB   = r_wstrb;
  assign M_AXI_WVALID  = r_wvalid;
  assign M_AXI_BREADY  = (r_state == WR_RESP);
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARPROT  = PROT_DEFAULT;
  assign M_AXI_ARVALID = (r_state == RD_ADDR);
  assign M_AXI_RREADY  = (r_state == RD_DATA);

  assign req_done  = (r_state == DONE) ? r_grant : '0;
  assign rsp_rdata = r_rdata;
  assign rsp_resp  = r_resp;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_axi_lite_rr_master_arbiter.sv
// Directed bench for the round-robin AXI-Lite master arbiter, driving it against
// a 4-register AXI-Lite slave model with programmable AWREADY delay and responses.
module tb_axi_lite_rr_master_arbiter;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int N  = 2;

  logic              M_AXI_ACLK;
  logic              M_AXI_ARESETN;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_write;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N*DW/8-1:0] req_wstrb;
  logic [N-1:0]      req_done;
  logic [DW-1:0]     rsp_rdata;
  logic [1:0]        rsp_resp;
  logic              busy;
  logic [AW-1:0]     M_AXI_AWADDR;
  logic [2:0]        M_AXI_AWPROT;
  logic              M_AXI_AWVALID;
  logic              M_AXI_AWREADY;
  logic [DW-1:0]     M_AXI_WDATA;
  logic [DW/8-1:0]   M_AXI_WSTRB;
  logic              M_AXI_WVALID;
  logic              M_AXI_WREADY;
  logic [1:0]        M_AXI_BRESP;
  logic              M_AXI_BVALID;
  logic              M_AXI_BREADY;
  logic [AW-1:0]     M_AXI_ARADDR;
  logic [2:0]        M_AXI_ARPROT;
  logic              M_AXI_ARVALID;
  logic              M_AXI_ARREADY;
  logic [DW-1:0]     M_AXI_RDATA;
  logic [1:0]        M_AXI_RRESP;
  logic              M_AXI_RVALID;
  logic              M_AXI_RREADY;

  int testsRun = 0;
  int testsFailed = 0;

  int          awDelay = 0;
  logic [1:0]  bRespCfg = 2'b00;
  logic [1:0]  rRespCfg = 2'b00;
  logic        holdR = 1'b0;

  int          lastLat;
  int          awHighCnt;
  int          wHighCnt;
  logic [1:0]  firstAwW;
  logic [N-1:0] doneVec;

  axi_lite_rr_master_arbiter #(
    .AXI_DATA_WIDTH (DW),
    .AXI_ADDR_WIDTH (AW),
    .N_REQ          (N)
  ) dut (
    .M_AXI_ACLK    (M_AXI_ACLK),
    .M_AXI_ARESETN (M_AXI_ARESETN),
    .req_valid     (req_valid),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_wstrb     (req_wstrb),
    .req_done      (req_done),
    .rsp_rdata     (rsp_rdata),
    .rsp_resp      (rsp_resp),
    .busy          (busy),
    .M_AXI_AWADDR  (M_AXI_AWADDR),
    .M_AXI_AWPROT  (M_AXI_AWPROT),
    .M_AXI_AWVALID (M_AXI_AWVALID),
    .M_AXI_AWREADY (M_AXI_AWREADY),
    .M_AXI_WDATA   (M_AXI_WDATA),
    .M_AXI_WSTRB   (M_AXI_WSTRB),
    .M_AXI_WVALID  (M_AXI_WVALID),
    .M_AXI_WREADY  (M_AXI_WREADY),
    .M_AXI_BRESP   (M_AXI_BRESP),
    .M_AXI_BVALID  (M_AXI_BVALID),
    .M_AXI_BREADY  (M_AXI_BREADY),
    .M_AXI_ARADDR  (M_AXI_ARADDR),
    .M_AXI_ARPROT  (M_AXI_ARPROT),
    .M_AXI_ARVALID (M_AXI_ARVALID),
    .M_AXI_ARREADY (M_AXI_ARREADY),
    .M_AXI_RDATA   (M_AXI_RDATA),
    .M_AXI_RRESP   (M_AXI_RRESP),
    .M_AXI_RVALID  (M_AXI_RVALID),
    .M_AXI_RREADY  (M_AXI_RREADY)
  );

  initial begin
    M_AXI_ACLK = 1'b0;
    forever #5 M_AXI_ACLK = ~M_AXI_ACLK;
  end

  // Slave model: four 32-bit registers at addr[3:2], B/R one cycle after handshake.
  logic [31:0] slvRegs [4];
  int          awCnt;
  logic        gotAw, gotW;
  logic [AW-1:0] awAddrL;
  logic [31:0] wDataL;
  logic [3:0]  wStrbL;
  logic        awHs, wHs, arHs;
  logic [AW-1:0] wAddrSel;
  logic [31:0] wDataSel;
  logic [3:0]  wStrbSel;

  assign M_AXI_AWREADY = M_AXI_AWVALID && (awCnt >= awDelay);
  assign M_AXI_WREADY  = M_AXI_WVALID;
  assign M_AXI_ARREADY = M_AXI_ARVALID;
  assign awHs = M_AXI_AWVALID && M_AXI_AWREADY;
  assign wHs  = M_AXI_WVALID && M_AXI_WREADY;
  assign arHs = M_AXI_ARVALID && M_AXI_ARREADY;
  assign wAddrSel = awHs ? M_AXI_AWADDR : awAddrL;
  assign wDataSel = wHs ? M_AXI_WDATA : wDataL;
  assign wStrbSel = wHs ? M_AXI_WSTRB : wStrbL;

  always @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      for (int i = 0; i < 4; i++) slvRegs[i] <= '0;
      awCnt <= 0; gotAw <= 1'b0; gotW <= 1'b0;
      awAddrL <= '0; wDataL <= '0; wStrbL <= '0;
      M_AXI_BVALID <= 1'b0; M_AXI_BRESP <= 2'b00;
      M_AXI_RVALID <= 1'b0; M_AXI_RRESP <= 2'b00; M_AXI_RDATA <= '0;
    end else begin
      if (M_AXI_AWVALID && !M_AXI_AWREADY) awCnt <= awCnt + 1;
      else awCnt <= 0;
      if (awHs) begin gotAw <= 1'b1; awAddrL <= M_AXI_AWADDR; end
      if (wHs) begin gotW <= 1'b1; wDataL <= M_AXI_WDATA; wStrbL <= M_AXI_WSTRB; end
      if (M_AXI_BVALID && M_AXI_BREADY) M_AXI_BVALID <= 1'b0;
      if ((gotAw || awHs) && (gotW || wHs)) begin
        for (int b = 0; b < 4; b++)
          if (wStrbSel[b]) slvRegs[wAddrSel[3:2]][8*b +: 8] <= wDataSel[8*b +: 8];
        gotAw <= 1'b0;
        gotW  <= 1'b0;
        M_AXI_BVALID <= 1'b1;
        M_AXI_BRESP  <= bRespCfg;
      end
      if (M_AXI_RVALID && M_AXI_RREADY) M_AXI_RVALID <= 1'b0;
      if (arHs && !holdR) begin
        M_AXI_RVALID <= 1'b1;
        M_AXI_RDATA  <= slvRegs[M_AXI_ARADDR[3:2]];
        M_AXI_RRESP  <= rRespCfg;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    testsRun++;
    if (got !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One transaction from a single requester; returns at the negedge of its done cycle.
  task automatic applyStimulus(input int r, input logic wr, input logic [AW-1:0] addr,
                               input logic [31:0] data, input logic [3:0] strb);
    int cnt;
    bit seen;
    @(negedge M_AXI_ACLK);
    req_write[r] = wr;
    req_addr[r*AW +: AW] = addr;
    req_wdata[r*DW +: DW] = data;
    req_wstrb[r*4 +: 4] = strb;
    req_valid[r] = 1'b1;
    cnt = 1; seen = 0; awHighCnt = 0; wHighCnt = 0; firstAwW = 2'b00; doneVec = '0;
    while (!seen && cnt < 60) begin
      @(negedge M_AXI_ACLK);
      cnt++;
      if (M_AXI_AWVALID) awHighCnt++;
      if (M_AXI_WVALID) wHighCnt++;
      if (cnt == 2) firstAwW = {M_AXI_AWVALID, M_AXI_WVALID};
      if (req_done != '0) begin
        seen = 1;
        doneVec = req_done;
      end
    end
    req_valid[r] = 1'b0;
    lastLat = cnt;
    checkOutput("doneSeen", 64'(seen), 64'd1);
  endtask

  logic [N-1:0] order [6];
  int           doneAt [6];
  int           nDone;
  int           cyc;
  logic [31:0]  r1Data;

  initial begin
    M_AXI_ARESETN = 1'b0;
    req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
    repeat (3) @(negedge M_AXI_ACLK);
    checkOutput("rstValidReady", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY}, 64'd0);
    checkOutput("rstBusyDone", {busy, req_done}, 64'd0);
    checkOutput("rstRsp", {rsp_rdata, rsp_resp}, 64'd0);
    checkOutput("rstAddrData", {M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WSTRB, M_AXI_WDATA}, 64'd0);
    M_AXI_ARESETN = 1'b1;

    // Basic write then readback through the other requester.
    applyStimulus(0, 1'b1, 4'h4, 32'hDEADBEEF, 4'hF);
    checkOutput("wrAwWTogether", firstAwW, 2'b11);
    checkOutput("wrDone", doneVec, 2'b01);
    checkOutput("wrResp", rsp_resp, 2'b00);
    checkOutput("wrLatency", lastLat, 4);
    @(negedge M_AXI_ACLK);
    checkOutput("idleBusyDone", {busy, req_done}, 3'b000);
    applyStimulus(1, 1'b0, 4'h4, 32'h0, 4'h0);
    checkOutput("rdDone", doneVec, 2'b10);
    checkOutput("rdData", rsp_rdata, 32'hDEADBEEF);
    checkOutput("rdLatency", lastLat, 4);

    // Simultaneous requests: last grant was 1, so req0 goes first.
    @(negedge M_AXI_ACLK);
    req_write = 2'b01;
    req_addr = {4'h8, 4'h8};
    req_wdata = {32'h0, 32'h11111111};
    req_wstrb = {4'h0, 4'hF};
    req_valid = 2'b11;
    nDone = 0; cyc = 0; r1Data = '0;
    while (nDone < 2 && cyc < 60) begin
      @(negedge M_AXI_ACLK);
      cyc++;
      if (req_done != '0) begin
        order[nDone] = req_done;
        doneAt[nDone] = cyc;
        nDone++;
        if (req_done[1]) r1Data = rsp_rdata;
        req_valid = req_valid & ~req_done;
      end
    end
    checkOutput("simCount", nDone, 2);
    checkOutput("simFirst", order[0], 2'b01);
    checkOutput("simSecond", order[1], 2'b10);
    checkOutput("simRdData", r1Data, 32'h11111111);
    checkOutput("simGap", doneAt[1] - doneAt[0], 4);
    @(negedge M_AXI_ACLK);
    checkOutput("donePulseOnce", req_done, 2'b00);

    // Both held for six transactions: grants must alternate starting at req0.
    req_write = 2'b00;
    req_addr = '0;
    req_valid = 2'b11;
    nDone = 0; cyc = 0;
    while (nDone < 6 && cyc < 200) begin
      @(negedge M_AXI_ACLK);
      cyc++;
      if (req_done != '0) begin
        checkOutput($sformatf("rrGrant%0d", nDone), req_done, (nDone % 2 == 0) ? 2'b01 : 2'b10);
        nDone++;
      end
    end
    req_valid = 2'b00;
    checkOutput("rrCount", nDone, 6);

    // Partial-strobe write merges into the existing register value.
    applyStimulus(0, 1'b1, 4'hC, 32'h12345678, 4'hF);
    applyStimulus(1, 1'b1, 4'hC, 32'hAAAABBBB, 4'b0011);
    applyStimulus(0, 1'b0, 4'hC, 32'h0, 4'h0);
    checkOutput("strbReadback", rsp_rdata, 32'h1234BBBB);
    checkOutput("strbResp", rsp_resp, 2'b00);

    // Slow AWREADY with an error response.
    awDelay = 3;
    bRespCfg = 2'b10;
    applyStimulus(0, 1'b1, 4'h0, 32'hCAFEF00D, 4'hF);
    checkOutput("slowAwCycles", awHighCnt, 4);
    checkOutput("slowWCycles", wHighCnt, 1);
    checkOutput("slowResp", rsp_resp, 2'b10);
    checkOutput("slowRdataKept", rsp_rdata, 32'h1234BBBB);
    checkOutput("slowLatency", lastLat, 7);
    awDelay = 0;
    bRespCfg = 2'b00;

    rRespCfg = 2'b11;
    applyStimulus(1, 1'b0, 4'h0, 32'h0, 4'h0);
    checkOutput("rdErrResp", rsp_resp, 2'b11);
    checkOutput("rdErrData", rsp_rdata, 32'hCAFEF00D);
    rRespCfg = 2'b00;

    // Reset while waiting in RD_DATA drops the transaction without a done pulse.
    holdR = 1'b1;
    @(negedge M_AXI_ACLK);
    req_write = 2'b00;
    req_addr = '0;
    req_valid = 2'b10;
    @(negedge M_AXI_ACLK);
    @(negedge M_AXI_ACLK);
    checkOutput("preRstRdData", {M_AXI_ARVALID, M_AXI_RREADY, busy}, 3'b011);
    #2;
    M_AXI_ARESETN = 1'b0;
    req_valid = 2'b11;
    #1;
    checkOutput("rstAsyncOut", {M_AXI_ARVALID, M_AXI_RREADY, busy}, 3'b000);
    checkOutput("rstNoDone", req_done, 2'b00);
    @(negedge M_AXI_ACLK);
    checkOutput("rstNoDoneLater", req_done, 2'b00);
    holdR = 1'b0;
    M_AXI_ARESETN = 1'b1;
    nDone = 0; cyc = 0;
    while (nDone < 2 && cyc < 60) begin
      @(negedge M_AXI_ACLK);
      cyc++;
      if (req_done != '0) begin
        order[nDone] = req_done;
        nDone++;
        req_valid = req_valid & ~req_done;
      end
    end
    checkOutput("postRstCount", nDone, 2);
    checkOutput("postRstFirst", order[0], 2'b01);
    checkOutput("postRstSecond", order[1], 2'b10);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
